// File: rtl/note_sequencer.sv
// note_sequencer: walks a song ROM of {duration, note} words, drives the
// current note and an envelope gate, and inserts an articulation gap at the
// tail of each note. Note 0 ends the song and note 255 is a rest.
module note_sequencer #(
   parameter int BOARD_CLOCKSPEED = 250000000,
   parameter int TICK_HZ          = 256,
   parameter int ADDR_W           = 9,
   parameter int GAP_TICKS        = 2,
   parameter int LOOP             = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [7:0]        note,
   output logic              gate,
   output logic              note_strobe,
   output logic              playing,
   output logic [2:0]        dbg_state
);

   localparam int TICK_DIV = BOARD_CLOCKSPEED / TICK_HZ;
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [8:0]    GAP9    = 9'(GAP_TICKS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_LOAD  = 3'd3,
      S_PLAY  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          note_q, note_d;
   logic                gate_q, gate_d;
   logic                strobe_q, strobe_d;
   logic                playing_q, playing_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                short_q, short_d;

   logic [7:0]          rom_note;
   logic [7:0]          dur_eff;
   logic [7:0]          cnt_dec;

   assign rom_note = rom_data[7:0];
   // A zero duration still sounds for one tick.
   assign dur_eff  = (rom_data[15:8] == 8'd0) ? 8'd1 : rom_data[15:8];
   assign cnt_dec  = cnt_q - 8'd1;

   // Next-state logic: stop beats start, start restarts from address 0.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      note_d    = note_q;
      gate_d    = gate_q;
      strobe_d  = 1'b0;
      presc_d   = presc_q;
      cnt_d     = cnt_q;
      short_d   = short_q;
      if (stop) begin
         state_d = S_IDLE;
         gate_d  = 1'b0;
      end else if (start) begin
         state_d = S_FETCH;
         addr_d  = '0;
         gate_d  = 1'b0;
         presc_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               gate_d = 1'b0;
            end
            S_FETCH: begin
               gate_d  = 1'b0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               gate_d  = 1'b0;
               state_d = S_LOAD;
            end
            S_LOAD: begin
               if (rom_note == 8'd0) begin
                  gate_d = 1'b0;
                  // An end marker at address 0 means an empty song: never loop on it.
                  if ((LOOP != 0) && (addr_q != '0)) begin
                     addr_d  = '0;
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  note_d   = rom_note;
                  strobe_d = 1'b1;
                  cnt_d    = dur_eff;
                  presc_d  = '0;
                  short_d  = ({1'b0, dur_eff} <= GAP9);
                  // At load the remaining ticks equal the duration, so the gap
                  // test always passes and only a rest keeps the gate low.
                  gate_d   = (rom_note != 8'hFF);
                  state_d  = S_PLAY;
               end
            end
            S_PLAY: begin
               if (presc_q == PRE_MAX) begin
                  presc_d = '0;
                  if (cnt_q <= 8'd1) begin
                     cnt_d   = 8'd0;
                     addr_d  = addr_q + ADDR_W'(1);
                     gate_d  = 1'b0;
                     state_d = S_FETCH;
                  end else begin
                     cnt_d  = cnt_dec;
                     gate_d = (note_q != 8'hFF) &&
                              (({1'b0, cnt_dec} > GAP9) || short_q);
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               gate_d  = 1'b0;
            end
         endcase
      end
      playing_d = (state_d != S_IDLE);
   end

   // State and registered outputs; reset overrides start and stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         note_q    <= 8'hFF;
         gate_q    <= 1'b0;
         strobe_q  <= 1'b0;
         playing_q <= 1'b0;
         presc_q   <= '0;
         cnt_q     <= 8'd0;
         short_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         note_q    <= note_d;
         gate_q    <= gate_d;
         strobe_q  <= strobe_d;
         playing_q <= playing_d;
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         short_q   <= short_d;
      end
   end

   assign rom_addr    = addr_q;
   assign note        = note_q;
   assign gate        = gate_q;
   assign note_strobe = strobe_q;
   assign playing     = playing_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (LOOP=0 and LOOP=1) with a 4-cycle
// tick and a 1-tick gap, each fed by its own registered 16-word ROM.
module tb_note_sequencer;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAITS = 3'd2;
  localparam logic [2:0] LOAD  = 3'd3;
  localparam logic [2:0] PLAY  = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;

  logic [3:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic [7:0]  note0, note1;
  logic        gate0, gate1, strb0, strb1, play0, play1;
  logic [2:0]  st0, st1;

  logic [15:0] rom0 [16];
  logic [15:0] rom1 [16];

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  // clock / registered ROMs
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    data0 <= rom0[addr0];
    data1 <= rom1[addr1];
  end

  note_sequencer #(.BOARD_CLOCKSPEED(16), .TICK_HZ(4), .ADDR_W(4), .GAP_TICKS(1), .LOOP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .rom_addr(addr0), .rom_data(data0),
    .note(note0), .gate(gate0), .note_strobe(strb0), .playing(play0), .dbg_state(st0));

  note_sequencer #(.BOARD_CLOCKSPEED(16), .TICK_HZ(4), .ADDR_W(4), .GAP_TICKS(1), .LOOP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .rom_addr(addr1), .rom_data(data1),
    .note(note1), .gate(gate1), .note_strobe(strb1), .playing(play1), .dbg_state(st1));

  typedef struct {
    logic       sel;
    logic       r, s, p;
    int         n;
    logic [2:0] st;
    logic [3:0] addr;
    logic [7:0] nt;
    logic       g, sb, pl;
  } vec_t;

  vec_t vecs[$];

  function automatic void mk(logic sel, logic r, logic s, logic p, int n, logic [2:0] st,
                             logic [3:0] addr, logic [7:0] nt, logic g, logic sb, logic pl);
    vec_t v;
    v.sel = sel; v.r = r; v.s = s; v.p = p; v.n = n; v.st = st;
    v.addr = addr; v.nt = nt; v.g = g; v.sb = sb; v.pl = pl;
    vecs.push_back(v);
  endfunction

  // driver: apply inputs away from the edge, advance one clock, sample at +1
  task automatic cyc(input logic r, input logic s, input logic p);
    rst = r; start = s; stop = p;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk(input string nm, input logic sel, input logic [2:0] st, input logic [3:0] addr,
                     input logic [7:0] nt, input logic g, input logic sb, input logic pl);
    if (sel == 1'b0) begin
      cmp({nm, " state"}, int'(st0), int'(st));
      cmp({nm, " rom_addr"}, int'(addr0), int'(addr));
      cmp({nm, " note"}, int'(note0), int'(nt));
      cmp({nm, " gate"}, int'(gate0), int'(g));
      cmp({nm, " strobe"}, int'(strb0), int'(sb));
      cmp({nm, " playing"}, int'(play0), int'(pl));
    end else begin
      cmp({nm, " state"}, int'(st1), int'(st));
      cmp({nm, " rom_addr"}, int'(addr1), int'(addr));
      cmp({nm, " note"}, int'(note1), int'(nt));
      cmp({nm, " gate"}, int'(gate1), int'(g));
      cmp({nm, " strobe"}, int'(strb1), int'(sb));
      cmp({nm, " playing"}, int'(play1), int'(pl));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom0[i] = 16'h0000;
      rom1[i] = 16'h0000;
    end
    rom0[0] = {8'd3, 8'd60};
    rom0[1] = {8'd0, 8'd0};
    rom1[0] = {8'd2, 8'd255};
    rom1[1] = {8'd1, 8'd64};
    rom1[2] = {8'd0, 8'd0};

    // single note, LOOP=0: 8 cycles gated, 4 cycles gap, then end marker
    mk(0, 1, 0, 0, 2, IDLE,  0, 255, 0, 0, 0);
    mk(0, 0, 1, 0, 1, FETCH, 0, 255, 0, 0, 1);
    mk(0, 0, 0, 0, 1, WAITS, 0, 255, 0, 0, 1);
    mk(0, 0, 0, 0, 1, LOAD,  0, 255, 0, 0, 1);
    mk(0, 0, 0, 0, 1, PLAY,  0, 60,  1, 1, 1);
    mk(0, 0, 0, 0, 7, PLAY,  0, 60,  1, 0, 1);
    mk(0, 0, 0, 0, 4, PLAY,  0, 60,  0, 0, 1);
    mk(0, 0, 0, 0, 1, FETCH, 1, 60,  0, 0, 1);
    mk(0, 0, 0, 0, 1, WAITS, 1, 60,  0, 0, 1);
    mk(0, 0, 0, 0, 1, LOAD,  1, 60,  0, 0, 1);
    mk(0, 0, 0, 0, 3, IDLE,  1, 60,  0, 0, 0);
    // rest then short note, LOOP=1: wraps back to address 0
    mk(1, 1, 0, 0, 2, IDLE,  0, 255, 0, 0, 0);
    mk(1, 0, 1, 0, 1, FETCH, 0, 255, 0, 0, 1);
    mk(1, 0, 0, 0, 1, WAITS, 0, 255, 0, 0, 1);
    mk(1, 0, 0, 0, 1, LOAD,  0, 255, 0, 0, 1);
    mk(1, 0, 0, 0, 1, PLAY,  0, 255, 0, 1, 1);
    mk(1, 0, 0, 0, 7, PLAY,  0, 255, 0, 0, 1);
    mk(1, 0, 0, 0, 1, FETCH, 1, 255, 0, 0, 1);
    mk(1, 0, 0, 0, 1, WAITS, 1, 255, 0, 0, 1);
    mk(1, 0, 0, 0, 1, LOAD,  1, 255, 0, 0, 1);
    mk(1, 0, 0, 0, 1, PLAY,  1, 64,  1, 1, 1);
    mk(1, 0, 0, 0, 3, PLAY,  1, 64,  1, 0, 1);
    mk(1, 0, 0, 0, 1, FETCH, 2, 64,  0, 0, 1);
    mk(1, 0, 0, 0, 1, WAITS, 2, 64,  0, 0, 1);
    mk(1, 0, 0, 0, 1, LOAD,  2, 64,  0, 0, 1);
    mk(1, 0, 0, 0, 1, FETCH, 0, 64,  0, 0, 1);
    mk(1, 0, 0, 0, 1, WAITS, 0, 64,  0, 0, 1);
    mk(1, 0, 0, 0, 1, LOAD,  0, 64,  0, 0, 1);
    mk(1, 0, 0, 0, 1, PLAY,  0, 255, 0, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        cyc(vecs[i].r, (k == 0) ? vecs[i].s : 1'b0, (k == 0) ? vecs[i].p : 1'b0);
        chk($sformatf("row%0d.%0d", i, k), vecs[i].sel, vecs[i].st, vecs[i].addr,
            vecs[i].nt, vecs[i].g, vecs[i].sb, vecs[i].pl);
      end
    end

    // start while playing note 64 at address 1 restarts from address 0
    for (int k = 0; k < 11; k++) cyc(0, 0, 0);
    chk("pre_restart", 1, PLAY, 1, 64, 1, 1, 1);
    cyc(0, 1, 0);
    chk("restart", 1, FETCH, 0, 64, 0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("restart_load", 1, PLAY, 0, 255, 0, 1, 1);

    // stop and start together mid-note: stop wins, note held
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0);
    chk("mid_play", 0, PLAY, 0, 60, 1, 0, 1);
    cyc(0, 1, 1);
    chk("stop_start", 0, IDLE, 0, 60, 0, 0, 0);
    cyc(0, 0, 0);
    chk("stop_hold", 0, IDLE, 0, 60, 0, 0, 0);

    // reset together with start, mid-note: reset values, no further fetch
    cyc(0, 1, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0);
    chk("pre_rst", 0, PLAY, 0, 60, 1, 0, 1);
    cyc(1, 1, 0);
    chk("rst_start", 0, IDLE, 0, 255, 0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_quiet", 0, IDLE, 0, 255, 0, 0, 0);

    // empty song on the looping instance: ends after LOAD, never sounds
    for (int i = 0; i < 16; i++) rom1[i] = 16'h0000;
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("empty_fetch", 1, FETCH, 0, 255, 0, 0, 1);
    cyc(0, 0, 0);
    chk("empty_wait", 1, WAITS, 0, 255, 0, 0, 1);
    cyc(0, 0, 0);
    chk("empty_load", 1, LOAD, 0, 255, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0);
      chk($sformatf("empty_idle%0d", k), 1, IDLE, 0, 255, 0, 0, 0);
    end

    // sixteen short notes, no end marker: address wraps 15 -> 0
    for (int i = 0; i < 16; i++) rom1[i] = {8'd1, 8'd62};
    for (int k = 0; k < 17; k++) exp_q.push_back(4'(k % 16));
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("wrap_first", 1, FETCH, 0, 255, 0, 0, 1);
    for (int k = 0; k < 17; k++) begin
      logic [3:0] ea;
      ea = exp_q.pop_front();
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk($sformatf("wrap%0d_strobe", k), 1, PLAY, ea, 62, 1, 1, 1);
      for (int j = 0; j < 3; j++) cyc(0, 0, 0);
      chk($sformatf("wrap%0d_hold", k), 1, PLAY, ea, 62, 1, 0, 1);
      cyc(0, 0, 0);
      chk($sformatf("wrap%0d_next", k), 1, FETCH, ea + 4'd1, 62, 0, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
